// File: rtl/twiddle_pkg.sv
// Shared types and constants for the twiddle ROM scheduler.
package twiddle_pkg;
  localparam int TW_W = 18;
  localparam logic signed [TW_W-1:0] UNITY_REAL = 18'sd65536;
  localparam logic signed [TW_W-1:0] UNITY_IMG  = 18'sd0;

  typedef enum logic {IDLE, RUN} state_e;

  // Per-index flags that travel alongside the ROM read.
  typedef struct packed {
    logic unity;
    logic id;
    logic last;
  } tw_tag_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered preference pointer.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);
  logic r_ptr;

  // r_ptr names the preferred requester; the other only wins when the preferred one is idle.
  always_comb begin
    o_gnt    = 2'b00;
    o_gnt[0] = i_req[0] & (~r_ptr | ~i_req[1]);
    o_gnt[1] = i_req[1] & ( r_ptr | ~i_req[0]);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst)         r_ptr <= 1'b0;
    else if (i_advance) r_ptr <= o_gnt[0];
  end
endmodule

// File: rtl/twiddle_rom_scheduler.sv
// Frame-level round-robin sharing of one twiddle ROM pair between two FFT stage
// requesters; unity is substituted in the second half-frame, flags aligned to ROM latency.
module twiddle_rom_scheduler
  import twiddle_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int ADDR_W    = 4,
  parameter int STRIDE0   = 1,
  parameter int STRIDE1   = 2,
  parameter int ROM_LAT   = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_req,
  output logic [1:0]             o_gnt,
  output logic                   o_busy,
  output logic [ADDR_W-1:0]      o_rom_addr,
  input  logic signed [TW_W-1:0] i_rom_real,
  input  logic signed [TW_W-1:0] i_rom_img,
  output logic                   o_tw_valid,
  output logic                   o_tw_id,
  output logic                   o_tw_last,
  output logic signed [TW_W-1:0] o_tw_real,
  output logic signed [TW_W-1:0] o_tw_img
);
  localparam int            KW     = $clog2(FRAME_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(FRAME_LEN - 1);

  state_e            r_state, w_state_nxt;
  logic [KW-1:0]     r_k, w_k_issue;
  logic              r_owner, w_owner;
  logic              w_arb_en, w_grant, w_issue;
  logic              w_unity, w_last;
  logic [1:0]        w_arb_gnt;
  logic [ADDR_W-1:0] w_stride, w_addr, r_addr;
  tw_tag_t           w_tag_in, w_tag_out;
  logic [ROM_LAT:0]  r_vld_pipe;
  tw_tag_t           r_tag_pipe [ROM_LAT:0];

  rr_arb2 u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .i_advance (w_grant),
    .o_gnt     (w_arb_gnt)
  );

  // r_k is the frame index currently on rom_addr; the index being issued this
  // cycle is w_k_issue. A grant issues index 0 in the same cycle, including the
  // back-to-back case at r_k==K_LAST, so frames chain without a bubble.
  always_comb begin
    w_arb_en    = i_rst && ((r_state == IDLE) || (r_k == K_LAST));
    w_grant     = w_arb_en && (i_req != 2'b00);
    w_issue     = w_grant || ((r_state == RUN) && (r_k != K_LAST));
    w_k_issue   = w_grant ? '0 : r_k + 1'b1;
    w_owner     = w_grant ? w_arb_gnt[1] : r_owner;
    w_state_nxt = w_issue ? RUN : IDLE;
    o_gnt       = w_grant ? w_arb_gnt : 2'b00;
  end

  // FRAME_LEN is a power of two, so the upper half-frame is exactly the MSB of k.
  always_comb begin
    w_stride = w_owner ? ADDR_W'(STRIDE1) : ADDR_W'(STRIDE0);
    w_unity  = w_k_issue[KW-1];
    w_last   = (w_k_issue == K_LAST);
    w_addr   = w_unity ? '0 : ADDR_W'(ADDR_W'(w_k_issue) * w_stride);
    w_tag_in = '0;
    if (w_issue) begin
      w_tag_in.unity = w_unity;
      w_tag_in.id    = w_owner;
      w_tag_in.last  = w_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_issue ? w_k_issue : '0;
      r_owner <= w_owner;
    end
  end

  // Stage 0 sits alongside rom_addr; stage ROM_LAT lines up with ROM data.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_addr     <= '0;
      r_vld_pipe <= '0;
      for (int i = 0; i <= ROM_LAT; i++) r_tag_pipe[i] <= '0;
    end else begin
      r_addr        <= w_issue ? w_addr : '0;
      r_vld_pipe    <= {r_vld_pipe[ROM_LAT-1:0], w_issue};
      r_tag_pipe[0] <= w_tag_in;
      for (int i = 1; i <= ROM_LAT; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];
    end
  end

  assign w_tag_out = r_tag_pipe[ROM_LAT];

  always_comb begin
    o_busy     = (r_state == RUN);
    o_rom_addr = r_addr;
    o_tw_valid = r_vld_pipe[ROM_LAT];
    o_tw_id    = r_vld_pipe[ROM_LAT] & w_tag_out.id;
    o_tw_last  = r_vld_pipe[ROM_LAT] & w_tag_out.last;
    o_tw_real  = '0;
    o_tw_img   = '0;
    if (r_vld_pipe[ROM_LAT]) begin
      o_tw_real = w_tag_out.unity ? UNITY_REAL : i_rom_real;
      o_tw_img  = w_tag_out.unity ? UNITY_IMG  : i_rom_img;
    end
  end
endmodule

// File: tb/tb_twiddle_rom_scheduler.sv
// Bench: two scheduler builds (ROM_LAT 1 and 3) share stimulus; a frame-level model
// predicts every cycle's outputs, plus literal spot checks of directed scenarios.
module tb_twiddle_rom_scheduler;
  localparam int FL = 16;
  localparam int AW = 4;
  localparam int S0 = 1;
  localparam int S1 = 2;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req;

  logic [1:0]        gnt   [2];
  logic              busy  [2];
  logic [AW-1:0]     addr  [2];
  logic              vld   [2];
  logic              tid   [2];
  logic              tlast [2];
  logic signed [17:0] treal [2];
  logic signed [17:0] timg  [2];
  logic signed [17:0] rreal [2];
  logic signed [17:0] rimg  [2];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  twiddle_rom_scheduler #(.FRAME_LEN(FL), .ADDR_W(AW), .STRIDE0(S0), .STRIDE1(S1), .ROM_LAT(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt[0]), .o_busy(busy[0]), .o_rom_addr(addr[0]),
    .i_rom_real(rreal[0]), .i_rom_img(rimg[0]), .o_tw_valid(vld[0]), .o_tw_id(tid[0]),
    .o_tw_last(tlast[0]), .o_tw_real(treal[0]), .o_tw_img(timg[0]));

  twiddle_rom_scheduler #(.FRAME_LEN(FL), .ADDR_W(AW), .STRIDE0(S0), .STRIDE1(S1), .ROM_LAT(3)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_gnt(gnt[1]), .o_busy(busy[1]), .o_rom_addr(addr[1]),
    .i_rom_real(rreal[1]), .i_rom_img(rimg[1]), .o_tw_valid(vld[1]), .o_tw_id(tid[1]),
    .o_tw_last(tlast[1]), .o_tw_real(treal[1]), .o_tw_img(timg[1]));

  // ROM models: real = addr*1000, img = -addr*1000, registered with 1 or 3 cycles latency.
  logic [AW-1:0] ra0;
  logic [AW-1:0] ra1 [3];
  always @(posedge clk) begin
    ra0    <= addr[0];
    ra1[0] <= addr[1];
    ra1[1] <= ra1[0];
    ra1[2] <= ra1[1];
  end
  always_comb begin
    rreal[0] = 18'(int'(ra0) * 1000);
    rimg[0]  = 18'(-(int'(ra0) * 1000));
    rreal[1] = 18'(int'(ra1[2]) * 1000);
    rimg[1]  = 18'(-(int'(ra1[2]) * 1000));
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Expected-output timeline, ring-indexed by cycle number.
  int e_addr [64];
  int e_busy [64];
  int e_vld  [2][64];
  int e_id   [2][64];
  int e_last [2][64];
  int e_re   [2][64];
  int e_im   [2][64];
  int pref    = 0;
  int next_ok = 0;

  function automatic void clr(input int i);
    e_addr[i] = 0;
    e_busy[i] = 0;
    for (int d = 0; d < 2; d++) begin
      e_vld[d][i] = 0; e_id[d][i] = 0; e_last[d][i] = 0; e_re[d][i] = 0; e_im[d][i] = 0;
    end
  endfunction

  // Model: a frame granted in cycle c puts index j on rom_addr at c+1+j and its
  // twiddle out at c+1+LAT+j; the next grant may not come before c+FL.
  always @(negedge clk) begin
    int s, id, sl, a;
    logic [1:0] g;
    if (chk_en) begin
      s = cyc % 64;
      g = 2'b00;
      if (!rst) begin
        for (int i = 0; i < 64; i++) if (i != s) clr(i);
        pref = 0;
        next_ok = cyc + 1;
      end else if (cyc >= next_ok && req != 2'b00) begin
        id = req[pref] ? pref : 1 - pref;
        g = (id == 1) ? 2'b10 : 2'b01;
        pref = 1 - id;
        next_ok = cyc + FL;
        for (int j = 0; j < FL; j++) begin
          a = (j < FL/2) ? (j * ((id == 1) ? S1 : S0)) % (1 << AW) : 0;
          sl = (cyc + 1 + j) % 64;
          e_addr[sl] = a;
          e_busy[sl] = 1;
          for (int d = 0; d < 2; d++) begin
            sl = (cyc + 1 + lat(d) + j) % 64;
            e_vld[d][sl]  = 1;
            e_id[d][sl]   = id;
            e_last[d][sl] = (j == FL-1) ? 1 : 0;
            e_re[d][sl]   = (j < FL/2) ? a * 1000 : 65536;
            e_im[d][sl]   = (j < FL/2) ? -a * 1000 : 0;
          end
        end
      end
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("gnt[%0d]", d), int'(gnt[d]), int'(g));
        chk($sformatf("busy[%0d]", d), int'(busy[d]), e_busy[s]);
        chk($sformatf("rom_addr[%0d]", d), int'(addr[d]), e_addr[s]);
        chk($sformatf("tw_valid[%0d]", d), int'(vld[d]), e_vld[d][s]);
        if (e_vld[d][s] != 0) begin
          chk($sformatf("tw_id[%0d]", d), int'(tid[d]), e_id[d][s]);
          chk($sformatf("tw_last[%0d]", d), int'(tlast[d]), e_last[d][s]);
          chk($sformatf("tw_real[%0d]", d), int'(treal[d]), e_re[d][s]);
          chk($sformatf("tw_img[%0d]", d), int'(timg[d]), e_im[d][s]);
        end
      end
      clr(s);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic at(input int t);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (cyc < t && g < 100);
    if (cyc != t) begin
      n_cmp++; n_bad++;
      $display("FAIL at: reached cycle %0d, wanted %0d", cyc, t);
    end
  endtask

  task automatic wait_gnt(output int t);
    int g;
    g = 0;
    t = -1;
    while (t < 0 && g < 40) begin
      @(negedge clk);
      g++;
      if (gnt[0] != 2'b00) t = cyc;
    end
    if (t < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_gnt: no grant within 40 cycles, got 0 expected a grant");
      t = cyc;
    end
  endtask

  initial begin
    int t;
    rst = 1'b0;
    req = 2'b00;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b1;
    tick();

    // single requester 0
    req = 2'b01;
    wait_gnt(t);
    chk("t1 gnt", int'(gnt[0]), 1);
    tick(); req = 2'b00;
    at(t+1);  chk("t1 vld T+1", int'(vld[0]), 0);
    at(t+2);  chk("t1 vld T+2", int'(vld[0]), 1); chk("t1 real T+2", int'(treal[0]), 0);
    at(t+3);  chk("t1 real T+3", int'(treal[0]), 1000); chk("t1 img T+3", int'(timg[0]), -1000);
              chk("t1 lat3 vld T+3", int'(vld[1]), 0);
    at(t+4);  chk("t1 lat3 vld T+4", int'(vld[1]), 1); chk("t1 lat3 real T+4", int'(treal[1]), 0);
    at(t+8);  chk("t1 addr T+8", int'(addr[0]), 7);
    at(t+9);  chk("t1 real T+9", int'(treal[0]), 7000); chk("t1 addr T+9", int'(addr[0]), 0);
    at(t+10); chk("t1 real T+10", int'(treal[0]), 65536); chk("t1 img T+10", int'(timg[0]), 0);
    at(t+17); chk("t1 last T+17", int'(tlast[0]), 1);
    at(t+18); chk("t1 vld T+18", int'(vld[0]), 0);

    // single requester 1, stride 2
    tick(); req = 2'b10;
    wait_gnt(t);
    chk("t2 gnt", int'(gnt[0]), 2);
    tick(); req = 2'b00;
    at(t+2);  chk("t2 addr T+2", int'(addr[0]), 2);
    at(t+5);  chk("t2 id T+5", int'(tid[0]), 1); chk("t2 lat3 id T+5", int'(tid[1]), 1);
    at(t+8);  chk("t2 addr T+8", int'(addr[0]), 14);
    at(t+22);

    // both held from reset: alternating back-to-back frames
    tick(); do_reset(); req = 2'b11;
    wait_gnt(t);
    chk("t3 gnt T", int'(gnt[0]), 1);
    at(t+16); chk("t3 gnt T+16", int'(gnt[0]), 2);
    at(t+17); chk("t3 last T+17", int'(tlast[0]), 1); chk("t3 id T+17", int'(tid[0]), 0);
    at(t+18); chk("t3 vld T+18", int'(vld[0]), 1); chk("t3 id T+18", int'(tid[0]), 1);
    at(t+32); chk("t3 gnt T+32", int'(gnt[0]), 1);
    tick(); req = 2'b00;
    at(t+55);

    // reset at k=5 aborts the frame
    tick(); do_reset(); req = 2'b01;
    wait_gnt(t);
    tick(); req = 2'b00;
    at(t+5);
    tick(); rst = 1'b0;
    at(t+6);  chk("t4 addr k=5", int'(addr[0]), 5);
    tick(); rst = 1'b1;
    at(t+7);
    chk("t4 busy", int'(busy[0]), 0); chk("t4 addr", int'(addr[0]), 0);
    chk("t4 vld", int'(vld[0]), 0); chk("t4 lat3 vld", int'(vld[1]), 0);
    chk("t4 real", int'(treal[0]), 0);
    tick(); req = 2'b01;
    wait_gnt(t);
    tick(); req = 2'b00;
    at(t+1);  chk("t4 restart addr", int'(addr[0]), 0);
    at(t+2);  chk("t4 restart addr+1", int'(addr[0]), 1);
    at(t+22);

    // short req[0] pulse during requester 1's frame is lost
    tick(); req = 2'b10;
    wait_gnt(t);
    tick(); req = 2'b00;
    at(t+5);
    tick(); req = 2'b01;
    tick(); req = 2'b00;
    at(t+16); chk("t5 no gnt", int'(gnt[0]), 0); chk("t5 busy k=15", int'(busy[0]), 1);
    at(t+17); chk("t5 idle", int'(busy[0]), 0);
    at(t+22);

    // randomized requests with occasional reset
    tick();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) req[0] = ~req[0];
      if ($urandom_range(7) == 0) req[1] = ~req[1];
      rst = ($urandom_range(63) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    req = 2'b00;
    rst = 1'b1;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
